// File: rtl/lut_add_checker.sv
// Golden-sum result checker for the adder under test.
// Delays the expected sum to match DUT latency and tallies pass/fail.
module lut_add_checker #(
   parameter int WIDTH      = 8,
   parameter int LATENCY    = 1,
   parameter int WARMUP     = 5000,
   parameter int NUM_CHECKS = 16
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [WIDTH-1:0] y,
   output logic [15:0]      pass_count,
   output logic [15:0]      fail_count,
   output logic             error,
   output logic [WIDTH-1:0] first_fail_exp,
   output logic [WIDTH-1:0] first_fail_got,
   output logic             done
);

   typedef enum logic [1:0] {
      S_WARM,
      S_CHECK,
      S_DONE
   } state_t;

   localparam int LD = (LATENCY == 0) ? 1 : LATENCY;
   localparam logic [19:0] WC_LAST =
      (WARMUP == 0) ? 20'd0 : 20'(WARMUP - 1);
   localparam logic [15:0] NC_LAST = 16'(NUM_CHECKS);

   state_t           state_q, state_d;
   logic [19:0]      wcnt_q, wcnt_d;
   logic [15:0]      ncmp_q, ncmp_d;
   logic [LD-1:0]    pv_q, pv_d;
   logic [WIDTH-1:0] pe_q [LD];
   logic [WIDTH-1:0] pe_d [LD];
   logic [15:0]      pass_q, pass_d;
   logic [15:0]      fail_q, fail_d;
   logic             err_q, err_d;
   logic [WIDTH-1:0] ffe_q, ffe_d;
   logic [WIDTH-1:0] ffg_q, ffg_d;
   logic             done_q, done_d;

   logic [WIDTH-1:0] sum;
   logic             cmp_v;
   logic [WIDTH-1:0] cmp_e;
   logic [15:0]      ncmp_nxt;

   assign sum = a + b;

   // LATENCY=0 compares the live operands; otherwise the pipe tail.
   always_comb begin
      if (LATENCY == 0) begin
         cmp_v = in_valid;
         cmp_e = sum;
      end else begin
         cmp_v = pv_q[LD-1];
         cmp_e = pe_q[LD-1];
      end
   end

   assign ncmp_nxt = ncmp_q + 16'd1;

   always_comb begin
      state_d = state_q;
      wcnt_d  = wcnt_q;
      ncmp_d  = ncmp_q;
      pass_d  = pass_q;
      fail_d  = fail_q;
      err_d   = err_q;
      ffe_d   = ffe_q;
      ffg_d   = ffg_q;
      done_d  = done_q;
      pv_d[0] = (state_q == S_CHECK) & in_valid;
      pe_d[0] = sum;
      for (int i = 1; i < LD; i++) begin
         pv_d[i] = pv_q[i-1];
         pe_d[i] = pe_q[i-1];
      end
      unique case (state_q)
         S_WARM: begin
            wcnt_d = wcnt_q + 20'd1;
            if (WARMUP == 0 || wcnt_q == WC_LAST)
               state_d = S_CHECK;
         end
         S_CHECK: begin
            if (cmp_v) begin
               ncmp_d = ncmp_nxt;
               if (y == cmp_e) begin
                  if (pass_q != 16'hFFFF)
                     pass_d = pass_q + 16'd1;
               end else begin
                  if (fail_q != 16'hFFFF)
                     fail_d = fail_q + 16'd1;
                  if (!err_q) begin
                     err_d = 1'b1;
                     ffe_d = cmp_e;
                     ffg_d = y;
                  end
               end
               if (ncmp_nxt == NC_LAST) begin
                  state_d = S_DONE;
                  done_d  = 1'b1;
               end
            end
         end
         S_DONE: ;
         default: state_d = S_WARM;
      endcase
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         state_q <= S_WARM;
         wcnt_q  <= '0;
         ncmp_q  <= '0;
         pv_q    <= '0;
         for (int i = 0; i < LD; i++)
            pe_q[i] <= '0;
         pass_q  <= '0;
         fail_q  <= '0;
         err_q   <= 1'b0;
         ffe_q   <= '0;
         ffg_q   <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         wcnt_q  <= wcnt_d;
         ncmp_q  <= ncmp_d;
         pv_q    <= pv_d;
         for (int i = 0; i < LD; i++)
            pe_q[i] <= pe_d[i];
         pass_q  <= pass_d;
         fail_q  <= fail_d;
         err_q   <= err_d;
         ffe_q   <= ffe_d;
         ffg_q   <= ffg_d;
         done_q  <= done_d;
      end
   end

   assign pass_count     = pass_q;
   assign fail_count     = fail_q;
   assign error          = err_q;
   assign first_fail_exp = ffe_q;
   assign first_fail_got = ffg_q;
   assign done           = done_q;

endmodule

// File: tb/tb_lut_add_checker.sv
// Directed bench for lut_add_checker: LATENCY=1 and LATENCY=0 instances,
// WARMUP=4, NUM_CHECKS=4.
module tb_lut_add_checker;

   logic       clock = 1'b0;
   logic       reset = 1'b0;
   logic       in_valid = 1'b0;
   logic [7:0] a = '0;
   logic [7:0] b = '0;
   logic [7:0] y = '0;
   logic       y0_bad = 1'b0;
   logic [7:0] y0;

   logic [15:0] pass1, fail1, pass0, fail0;
   logic        err1, done1, err0, done0;
   logic [7:0]  ffe1, ffg1, ffe0, ffg0;

   int passed = 0;
   int total  = 0;

   assign y0 = 8'(a + b) ^ {8{y0_bad}};

   always #5 clock = ~clock;

   lut_add_checker #(
      .WIDTH(8), .LATENCY(1), .WARMUP(4), .NUM_CHECKS(4)
   ) u1 (
      .clock(clock), .reset(reset), .in_valid(in_valid),
      .a(a), .b(b), .y(y),
      .pass_count(pass1), .fail_count(fail1), .error(err1),
      .first_fail_exp(ffe1), .first_fail_got(ffg1), .done(done1)
   );

   lut_add_checker #(
      .WIDTH(8), .LATENCY(0), .WARMUP(4), .NUM_CHECKS(4)
   ) u0 (
      .clock(clock), .reset(reset), .in_valid(in_valid),
      .a(a), .b(b), .y(y0),
      .pass_count(pass0), .fail_count(fail0), .error(err0),
      .first_fail_exp(ffe0), .first_fail_got(ffg0), .done(done0)
   );

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      total++;
      assert (got === exp) passed++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic do_reset();
      reset    = 1'b0;
      in_valid = 1'b0;
      a = '0; b = '0; y = '0; y0_bad = 1'b0;
      step();
      reset = 1'b1;
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_pass"}, 32'(pass1), 0);
      chk({tag, "_fail"}, 32'(fail1), 0);
      chk({tag, "_err"},  32'(err1),  0);
      chk({tag, "_ffe"},  32'(ffe1),  0);
      chk({tag, "_ffg"},  32'(ffg1),  0);
      chk({tag, "_done"}, 32'(done1), 0);
   endtask

   initial begin
      // Test 1: basic pass
      do_reset();
      chk_zero("rst");
      repeat (4) step();
      in_valid = 1; a = 8'h00; b = 8'hFE;
      step();
      in_valid = 0; y = 8'hFE;
      step();
      chk("t1_pass", 32'(pass1), 1);
      chk("t1_fail", 32'(fail1), 0);
      chk("t1_err",  32'(err1),  0);

      // Test 2: wrap-around
      do_reset();
      repeat (4) step();
      in_valid = 1; a = 8'hFF; b = 8'h01;
      step();
      a = 8'h80; b = 8'h80; y = 8'h00;
      step();
      in_valid = 0; y = 8'h00;
      step();
      chk("t2_pass", 32'(pass1), 2);
      chk("t2_fail", 32'(fail1), 0);

      // Test 3: mismatch capture
      do_reset();
      repeat (4) step();
      in_valid = 1; a = 8'h02; b = 8'h03;
      step();
      a = 8'h01; b = 8'h01; y = 8'h00;
      step();
      in_valid = 0; y = 8'h07;
      step();
      chk("t3_pass", 32'(pass1), 0);
      chk("t3_fail", 32'(fail1), 2);
      chk("t3_err",  32'(err1),  1);
      chk("t3_ffe",  32'(ffe1),  8'h05);
      chk("t3_ffg",  32'(ffg1),  8'h00);

      // Test 4: warm-up masking, first compare uses cycle-4 operands
      do_reset();
      for (int c = 0; c < 5; c++) begin
         in_valid = 1; a = 8'(c); b = 8'h01; y = 8'hAA;
         if (c > 0) begin
            chk($sformatf("t4_pass_c%0d", c), 32'(pass1), 0);
            chk($sformatf("t4_fail_c%0d", c), 32'(fail1), 0);
         end
         step();
      end
      in_valid = 0; y = 8'h05;
      chk("t4_pass_c5", 32'(pass1), 0);
      chk("t4_fail_c5", 32'(fail1), 0);
      step();
      chk("t4_pass_c6", 32'(pass1), 1);
      chk("t4_fail_c6", 32'(fail1), 0);

      // Test 5: completion, extra pairs ignored; LATENCY=0 done earlier
      do_reset();
      repeat (4) step();
      for (int i = 0; i < 6; i++) begin
         in_valid = 1; a = 8'(i); b = 8'h10;
         if (i == 0) y = 8'h00;
         else if (i <= 4) y = 8'(i - 1 + 16);
         else y = ~8'(i - 1 + 16);
         y0_bad = (i >= 4);
         if (i == 3) chk("t5_done0_early", 32'(done0), 0);
         if (i == 4) begin
            chk("t5_done0", 32'(done0), 1);
            chk("t5_pass0", 32'(pass0), 4);
            chk("t5_done1_early", 32'(done1), 0);
         end
         if (i == 5) begin
            chk("t5_done1", 32'(done1), 1);
            chk("t5_pass1", 32'(pass1), 4);
         end
         step();
      end
      in_valid = 0; y = ~8'h15; y0_bad = 0;
      step();
      chk("t5_pass1_hold", 32'(pass1), 4);
      chk("t5_fail1_hold", 32'(fail1), 0);
      chk("t5_done1_hold", 32'(done1), 1);
      chk("t5_pass0_hold", 32'(pass0), 4);
      chk("t5_fail0_hold", 32'(fail0), 0);

      // Test 6: reset mid-run
      do_reset();
      repeat (4) step();
      in_valid = 1; a = 8'h01; b = 8'h01;
      step();
      a = 8'h02; b = 8'h02; y = 8'h02;
      step();
      in_valid = 0; y = 8'h00;
      step();
      chk("t6_pass_pre", 32'(pass1), 1);
      chk("t6_fail_pre", 32'(fail1), 1);
      chk("t6_err_pre",  32'(err1),  1);
      do_reset();
      chk_zero("t6_rst");
      for (int c = 0; c < 4; c++) begin
         in_valid = 1; a = 8'h03; b = 8'h03; y = 8'hAA;
         step();
      end
      chk("t6_warm_pass", 32'(pass1), 0);
      chk("t6_warm_fail", 32'(fail1), 0);
      in_valid = 1; a = 8'h09; b = 8'h01;
      step();
      in_valid = 0; y = 8'h0A;
      step();
      chk("t6_post_pass", 32'(pass1), 1);
      chk("t6_post_fail", 32'(fail1), 0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/lut_add_checker.md
# lut_add_checker

Self-checking result stage that sits directly downstream of the adder under test (`main`) in the regression bench. It takes the same operands driven into the DUT, computes the golden sum, delays it to line up with the DUT's result latency, compares it against the DUT's output, and accumulates pass/fail statistics. A warm-up window masks comparisons while GSR settles. A done flag tells the bench top when to `$finish`.

## Interface

Parameters:
- `WIDTH`, 8, operand/result width in bits.
- `LATENCY`, 1, DUT result latency in clock cycles; legal 0..15.
- `WARMUP`, 5000, cycles after reset release during which inputs are ignored; legal 0..2^20-1.
- `NUM_CHECKS`, 16, comparisons performed before `done`; legal 1..65535.

Ports:
- `clock`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  reset, synchronous, active-low.
- `in_valid`  in  1  operands `a`/`b` were presented to the DUT this cycle.
- `a`  in  WIDTH  operand A, as driven to the DUT.
- `b`  in  WIDTH  operand B, as driven to the DUT.
- `y`  in  WIDTH  DUT result.
- `pass_count`  out  16  comparisons that matched; saturating.
- `fail_count`  out  16  comparisons that mismatched; saturating.
- `error`  out  1  sticky; set on the first mismatch.
- `first_fail_exp`  out  WIDTH  expected value of the first mismatch.
- `first_fail_got`  out  WIDTH  DUT value of the first mismatch.
- `done`  out  1  sticky; `NUM_CHECKS` comparisons are complete.

## Operation

- **Reset.** While `reset`=0 at an edge:
  - FSM goes to WARMUP and the warm-up counter is cleared.
  - Pipeline valids are cleared.
  - All outputs are 0.
- **Golden model.** `exp = (a + b) mod 2^WIDTH`.
  - Unsigned wrap; no carry out.
  - Signed and unsigned interpretations are identical.
- **FSM states.**
  - WARMUP: the counter increments each cycle. Go to CHECK when the counter equals `WARMUP`-1. With `WARMUP`=0, go to CHECK at the first edge after reset release. `in_valid` is ignored and nothing enters the pipeline.
  - CHECK: each cycle, the pair {`in_valid`, `exp`} enters a `LATENCY`-deep shift pipeline. A comparison occurs when the pipeline output is valid; with `LATENCY`=0 this is `in_valid` itself, comparing in the same cycle.
  - DONE: terminal. No further comparisons. All outputs are frozen until reset.
- **Comparison.**
  - `y` == delayed `exp`: `pass_count` increments, saturating at 0xFFFF.
  - Otherwise `fail_count` increments, saturating at 0xFFFF. If `error`=0, then `error`, `first_fail_exp` and `first_fail_got` are set; later fails never overwrite them.
- **Completion.** A comparison-number counter reaches `NUM_CHECKS` on an edge. At that edge the FSM enters DONE and `done`=1. Entries still in flight are discarded.
- **Warm-up boundary.** Operands presented in WARMUP are never compared, even when `LATENCY`>0 would place their result inside CHECK.
- **Reset mid-operation.** Reset in any state returns everything to reset values on that edge. Partial counts are lost.

## Timing

- Operands with `in_valid`=1 in CHECK at cycle t are compared against `y` sampled at cycle t+`LATENCY`.
- Count, `error` and capture registers update at the end of cycle t+`LATENCY` and are visible from cycle t+`LATENCY`+1.
- `done` is visible in the same cycle as the counts from the final comparison.
- Back-to-back `in_valid` is fully supported: one comparison per cycle, no stalls, no backpressure.
- The first cycle in CHECK is cycle `WARMUP` after reset release, counting the first cycle with `reset`=1 as cycle 0.
- All outputs are registered; no combinational input-to-output path.

## Test plan

Parameters are `LATENCY`=1, `WARMUP`=4, `NUM_CHECKS`=4 unless stated otherwise.

1. **Basic pass.** a=0x00, b=0xFE, `in_valid` at the first CHECK cycle, `y`=0xFE one cycle later. Required: `pass_count`=1, `fail_count`=0, `error`=0.
2. **Wrap-around.** a=0xFF, b=0x01 then a=0x80, b=0x80, with `y`=0x00 at the respective +1 cycles. Required: `pass_count`=2, no fail.
3. **Mismatch capture.** a=0x02, b=0x03 with `y`=0x00, then a=0x01, b=0x01 with `y`=0x07. Required: `fail_count`=2, `error`=1, `first_fail_exp`=0x05, `first_fail_got`=0x00 (not overwritten by the second fail).
4. **Warm-up masking and boundary.** `in_valid`=1 every cycle from reset release, with `y` forced wrong throughout warm-up. Required: no counts change during the first 4 cycles; the first comparison uses operands from cycle 4.
5. **Completion.** 6 back-to-back valid pairs. Required: `pass_count`=4, `done`=1 after the 4th comparison; the 5th and 6th pairs change nothing. With `LATENCY`=0, `done` is visible one cycle earlier relative to the operands.
6. **Reset mid-run.** Drop `reset` for one edge after 2 comparisons with 1 fail. Required: every output reads 0 on the next cycle and warm-up restarts from 0.
